output_frame_sequencer: RTL and testbench

//  Ping-pong scheduler between the frame producer (processing core writing result banks) and the output fetch engine.

---
 rtl/output_frame_sequencer_if.sv | 28 ++
 rtl/output_frame_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_output_frame_sequencer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/output_frame_sequencer_if.sv
// Handshake bundle between the frame sequencer, the frame producer and the output fetch engine.
// The master modport is the sequencer side; the slave modport is the producer/fetch-engine side.
interface output_frame_sequencer_if;
  logic prod_frame_done;
  logic prod_bank;
  logic prod_stall;
  logic fetch_start;
  logic fetch_base_offset;
  logic fetch_done;

  modport master (
    input  prod_frame_done,
    input  fetch_done,
    output prod_bank,
    output prod_stall,
    output fetch_start,
    output fetch_base_offset
  );

  modport slave (
    output prod_frame_done,
    output fetch_done,
    input  prod_bank,
    input  prod_stall,
    input  fetch_start,
    input  fetch_base_offset
  );
endinterface

// File: rtl/output_frame_sequencer.sv
// Ping-pong ownership of two output banks between the frame producer and the fetch engine.
// Optional RUN watchdog is compiled in when OUTPUT_SEQ_WDOG_EN is defined.
module output_frame_sequencer #(
  parameter int MIN_GAP     = 2,
  parameter int WDOG_CYCLES = 400000,
  parameter int CNT_W       = 16
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        enable,
  output_frame_sequencer_if.master    bus,
  output logic                        busy,
  output logic [CNT_W-1:0]            frames_sent,
  output logic                        overrun,
  output logic                        wdog_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

  state_t           state_r, state_nxt;
  logic [GAP_W-1:0] gap_cnt_r, gap_cnt_nxt;
  logic [1:0]       full_r, full_after_s;
  logic             cons_bank_r;
  logic             prod_bank_r, prod_bank_nxt;
  logic             prod_stall_r, prod_stall_nxt;
  logic             start_r;
  logic             base_r;
  logic             busy_r;
  logic [CNT_W-1:0] frames_r;
  logic             overrun_r;
  logic             wdog_r;
  logic             release_s;
  logic             accept_s;
  logic             toggle_s;
  logic             wdog_hit_s;
  logic             wdog_expire_s;
  logic             abort_s;

  // Bank bookkeeping: release is applied before the producer's toggle decision.
  always_comb begin
    release_s       = (state_r == DRAIN) && !bus.fetch_done;
    accept_s        = bus.prod_frame_done && !prod_stall_r;
    full_after_s[0] = (accept_s && (prod_bank_r == 1'b0)) ? 1'b1 :
                      (release_s && (cons_bank_r == 1'b0)) ? 1'b0 : full_r[0];
    full_after_s[1] = (accept_s && (prod_bank_r == 1'b1)) ? 1'b1 :
                      (release_s && (cons_bank_r == 1'b1)) ? 1'b0 : full_r[1];
    toggle_s        = full_after_s[prod_bank_r] && !full_after_s[~prod_bank_r];
    prod_bank_nxt   = toggle_s ? ~prod_bank_r : prod_bank_r;
    prod_stall_nxt  = full_after_s[prod_bank_nxt];
  end

  // Consumer FSM next-state logic.
  always_comb begin
    state_nxt   = state_r;
    gap_cnt_nxt = gap_cnt_r;
    wdog_hit_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable && full_r[cons_bank_r]) begin
          state_nxt   = LOAD;
          gap_cnt_nxt = '0;
        end else begin
          state_nxt   = IDLE;
        end
      end
      LOAD: begin
        if (gap_cnt_r == GAP_W'(MIN_GAP - 1)) begin
          state_nxt   = RUN;
        end else begin
          gap_cnt_nxt = gap_cnt_r + GAP_W'(1);
        end
      end
      RUN: begin
        if (bus.fetch_done) begin
          state_nxt  = DRAIN;
        end else if (wdog_expire_s) begin
          state_nxt  = DRAIN;
          wdog_hit_s = 1'b1;
        end else begin
          state_nxt  = RUN;
        end
      end
      DRAIN: begin
        if (!bus.fetch_done) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DRAIN;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef OUTPUT_SEQ_WDOG_EN
  localparam int RUN_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

  logic [RUN_W-1:0] run_cnt_r;
  logic             abort_r;

  // RUN-cycle counter; held at zero outside RUN so it restarts on every RUN entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt_r <= '0;
      abort_r   <= 1'b0;
    end else begin
      if (state_r == RUN) begin
        run_cnt_r <= run_cnt_r + RUN_W'(1);
      end else begin
        run_cnt_r <= '0;
      end
      if (wdog_hit_s) begin
        abort_r <= 1'b1;
      end else if (release_s) begin
        abort_r <= 1'b0;
      end
    end
  end

  assign wdog_expire_s = (run_cnt_r == RUN_W'(WDOG_CYCLES - 1));
  assign abort_s       = abort_r;
`else
  assign wdog_expire_s = 1'b0;
  assign abort_s       = 1'b0;
`endif

  // State, bank ownership and registered outputs; start is registered from the next state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      gap_cnt_r    <= '0;
      full_r       <= 2'b00;
      cons_bank_r  <= 1'b0;
      prod_bank_r  <= 1'b0;
      prod_stall_r <= 1'b0;
      start_r      <= 1'b0;
      base_r       <= 1'b0;
      busy_r       <= 1'b0;
      frames_r     <= '0;
      overrun_r    <= 1'b0;
      wdog_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt;
      gap_cnt_r    <= gap_cnt_nxt;
      full_r       <= full_after_s;
      prod_bank_r  <= prod_bank_nxt;
      prod_stall_r <= prod_stall_nxt;
      start_r      <= (state_nxt == RUN);
      busy_r       <= (state_nxt != IDLE);
      if (release_s) begin
        cons_bank_r <= ~cons_bank_r;
      end
      if ((state_r == IDLE) && (state_nxt == LOAD)) begin
        base_r <= cons_bank_r;
      end
      if (release_s && !abort_s) begin
        frames_r <= frames_r + CNT_W'(1);
      end
      if (bus.prod_frame_done && prod_stall_r) begin
        overrun_r <= 1'b1;
      end
      if (wdog_hit_s) begin
        wdog_r <= 1'b1;
      end
    end
  end

  assign bus.prod_bank         = prod_bank_r;
  assign bus.prod_stall        = prod_stall_r;
  assign bus.fetch_start       = start_r;
  assign bus.fetch_base_offset = base_r;
  assign busy                  = busy_r;
  assign frames_sent           = frames_r;
  assign overrun               = overrun_r;
  assign wdog_timeout          = wdog_r;

endmodule

// File: tb/tb_output_frame_sequencer.sv
// Directed bench for output_frame_sequencer: a cycle vector table plus hand-written multi-cycle sequences.
// The watchdog sequence follows OUTPUT_SEQ_WDOG_EN, with WDOG_CYCLES set to 100.
module tb_output_frame_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        busy;
  logic [15:0] frames_sent;
  logic        overrun;
  logic        wdog_timeout;

  output_frame_sequencer_if sif ();

  output_frame_sequencer #(
    .MIN_GAP     (2),
    .WDOG_CYCLES (100),
    .CNT_W       (16)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .bus          (sif),
    .busy         (busy),
    .frames_sent  (frames_sent),
    .overrun      (overrun),
    .wdog_timeout (wdog_timeout)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // {prod_bank, prod_stall, fetch_start, fetch_base_offset, busy, overrun} after the edge
  typedef struct {
    logic        en;
    logic        pfd;
    logic        fd;
    logic [5:0]  outs;
    logic [15:0] fs;
  } vec_t;

  vec_t vt[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {sif.prod_bank, sif.prod_stall, sif.fetch_start, sif.fetch_base_offset, busy, overrun};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic pick(input int sel);
    return (sel == 0) ? sif.fetch_start : busy;
  endfunction

  // sel 0 = fetch_start, 1 = busy; an expired budget shows up as a failed comparison
  task automatic wait_for(input string name, input int sel, input logic val, input int budget);
    int n = 0;
    while ((pick(sel) !== val) && (n < budget)) begin
      step();
      n++;
    end
    check(name, {31'd0, pick(sel)}, {31'd0, val});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable = 1'b0;
    sif.prod_frame_done = 1'b0;
    sif.fetch_done = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic pulse();
    sif.prod_frame_done = 1'b1;
    step();
    sif.prod_frame_done = 1'b0;
  endtask

  task automatic finish_frame(input string tag);
    wait_for({tag, "_start"}, 0, 1'b1, 20);
    repeat (3) step();
    sif.fetch_done = 1'b1;
    wait_for({tag, "_drop"}, 0, 1'b0, 5);
    repeat (8) step();
    sif.fetch_done = 1'b0;
    wait_for({tag, "_idle"}, 1, 1'b0, 5);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    int bases[4];
    int nseen;
    int pushes;
    int run_len;
    int tail;
    int low_cnt;
    int hi;
    logic prev_start;
    logic saw;

    // test 1 + test 2 as a cycle table, starting from reset with cons_bank=0
    vt[0]  = '{1'b1, 1'b1, 1'b0, 6'b100000, 16'd0};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 6'b100010, 16'd0};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 6'b100010, 16'd0};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 6'b101010, 16'd0};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 6'b101010, 16'd0};
    vt[5]  = '{1'b1, 1'b0, 1'b1, 6'b100010, 16'd0};
    vt[6]  = '{1'b1, 1'b0, 1'b1, 6'b100010, 16'd0};
    vt[7]  = '{1'b1, 1'b0, 1'b0, 6'b100000, 16'd1};
    vt[8]  = '{1'b0, 1'b1, 1'b0, 6'b000000, 16'd1};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 6'b010000, 16'd1};
    vt[10] = '{1'b0, 1'b1, 1'b0, 6'b010001, 16'd1};
    vt[11] = '{1'b1, 1'b0, 1'b0, 6'b010111, 16'd1};
    vt[12] = '{1'b1, 1'b0, 1'b0, 6'b010111, 16'd1};
    vt[13] = '{1'b1, 1'b0, 1'b0, 6'b011111, 16'd1};
    vt[14] = '{1'b1, 1'b0, 1'b1, 6'b010111, 16'd1};
    vt[15] = '{1'b1, 1'b0, 1'b0, 6'b100101, 16'd2};
    vt[16] = '{1'b1, 1'b0, 1'b0, 6'b100011, 16'd2};

    do_reset();
    check("reset_outs", {26'd0, outs()}, 32'd0);
    check("reset_frames", {16'd0, frames_sent}, 32'd0);
    check("reset_wdog", {31'd0, wdog_timeout}, 32'd0);

    for (int i = 0; i < 17; i++) begin
      enable = vt[i].en;
      sif.prod_frame_done = vt[i].pfd;
      sif.fetch_done = vt[i].fd;
      step();
      check($sformatf("vec%0d_outs", i), {26'd0, outs()}, {26'd0, vt[i].outs});
      check($sformatf("vec%0d_frames", i), {16'd0, frames_sent}, {16'd0, vt[i].fs});
    end
    sif.prod_frame_done = 1'b0;
    sif.fetch_done = 1'b0;
    finish_frame("t2_tail");
    check("t2_tail_frames", {16'd0, frames_sent}, 32'd3);
    check("t2_overrun_sticky", {31'd0, overrun}, 32'd1);

    // test 3: continuous producer, small fetch-engine model
    do_reset();
    enable = 1'b1;
    nseen = 0;
    pushes = 0;
    run_len = 0;
    tail = 0;
    low_cnt = 0;
    prev_start = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!sif.prod_stall && (pushes < 4)) begin
        sif.prod_frame_done = 1'b1;
        pushes++;
      end else begin
        sif.prod_frame_done = 1'b0;
      end
      if (sif.fetch_start) begin
        run_len++;
        if (run_len >= 20) sif.fetch_done = 1'b1;
      end else begin
        run_len = 0;
        if (sif.fetch_done) begin
          tail++;
          if (tail >= 9) begin
            sif.fetch_done = 1'b0;
            tail = 0;
          end
        end
      end
      step();
      if (sif.fetch_start && !prev_start) begin
        if (nseen < 4) bases[nseen] = int'(sif.fetch_base_offset);
        if (nseen > 0) check($sformatf("t3_gap%0d", nseen), (low_cnt >= 3) ? 32'd1 : 32'd0, 32'd1);
        nseen++;
      end
      low_cnt = sif.fetch_start ? 0 : low_cnt + 1;
      prev_start = sif.fetch_start;
      if ((frames_sent == 16'd4) && !busy) break;
    end
    sif.prod_frame_done = 1'b0;
    sif.fetch_done = 1'b0;
    check("t3_nframes", nseen, 32'd4);
    check("t3_base0", bases[0], 32'd0);
    check("t3_base1", bases[1], 32'd1);
    check("t3_base2", bases[2], 32'd0);
    check("t3_base3", bases[3], 32'd1);
    check("t3_frames", {16'd0, frames_sent}, 32'd4);

    // test 4: enable gating
    do_reset();
    pulse();
    saw = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (sif.fetch_start || busy) saw = 1'b1;
    end
    check("t4_disabled_quiet", {31'd0, saw}, 32'd0);
    enable = 1'b1;
    repeat (3) step();
    check("t4_launch_start", {31'd0, sif.fetch_start}, 32'd1);
    check("t4_launch_base", {31'd0, sif.fetch_base_offset}, 32'd0);
    enable = 1'b0;
    repeat (4) step();
    check("t4_run_holds", {31'd0, sif.fetch_start}, 32'd1);
    finish_frame("t4_done");
    check("t4_frames", {16'd0, frames_sent}, 32'd1);

    // test 5: reset in RUN (bank 1 is next for both sides after test 4)
    enable = 1'b1;
    pulse();
    wait_for("t5_start", 0, 1'b1, 10);
    check("t5_base", {31'd0, sif.fetch_base_offset}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_async_outs", {26'd0, outs()}, 32'd0);
    check("t5_async_frames", {16'd0, frames_sent}, 32'd0);
    step();
    reset_n = 1'b1;
    step();
    pulse();
    check("t5_prod_bank", {31'd0, sif.prod_bank}, 32'd1);
    repeat (2) step();
    check("t5_gap_low", {31'd0, sif.fetch_start}, 32'd0);
    step();
    check("t5_restart", {31'd0, sif.fetch_start}, 32'd1);
    check("t5_restart_base", {31'd0, sif.fetch_base_offset}, 32'd0);
    finish_frame("t5_done");
    check("t5_frames", {16'd0, frames_sent}, 32'd1);

    // test 6: fetch_done never arrives
    do_reset();
    enable = 1'b1;
    pulse();
    wait_for("t6_start", 0, 1'b1, 10);
    hi = 1;
`ifdef OUTPUT_SEQ_WDOG_EN
    while (sif.fetch_start && (hi < 300)) begin
      step();
      if (sif.fetch_start) hi++;
    end
    check("t6_run_cycles", hi, 32'd100);
    check("t6_wdog", {31'd0, wdog_timeout}, 32'd1);
    wait_for("t6_idle", 1, 1'b0, 5);
    repeat (5) step();
    check("t6_no_relaunch", {31'd0, busy}, 32'd0);
    check("t6_frames", {16'd0, frames_sent}, 32'd0);
    check("t6_stall", {31'd0, sif.prod_stall}, 32'd0);
`else
    for (int c = 0; c < 149; c++) begin
      step();
      if (sif.fetch_start) hi++;
    end
    check("t6_run_cycles", hi, 32'd150);
    check("t6_wdog", {31'd0, wdog_timeout}, 32'd0);
    finish_frame("t6_done");
    check("t6_frames", {16'd0, frames_sent}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
